// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared size/state encodings and alignment rule for the data memory.
package data_mem_pkg;
  typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10, SIZE_RSVD = 2'b11} size_t;
  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return size == SIZE_RSVD || (size == SIZE_HALF && lane[0]) || (size == SIZE_WORD && lane != 2'b00);
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half out of a little-endian word and extends it.
module mem_load_align import data_mem_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zeroExt,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    result = size == SIZE_BYTE ? {{24{b[7] & ~zeroExt}}, b} :
             size == SIZE_HALF ? {{16{h[15] & ~zeroExt}}, h} : word;
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable MIPS data memory with subword access, registered loads and
// a post-reset clear sequencer that zeroes the array and preloads one constant.
module data_mem_ctrl import data_mem_pkg::*; #(
  parameter int          DEPTH_WORDS = 128,
  parameter int          ADDR_WIDTH  = 9,
  parameter int          INIT_ADDR   = 13,
  parameter logic [31:0] INIT_VALUE  = 32'd3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [31:0]           ReadData,
  output logic                  ReadValid,
  output logic                  Ready,
  output logic                  AddrError
);
  localparam int IW = ADDR_WIDTH - 2;
  logic [3:0][7:0] mem [DEPTH_WORDS];
  state_t          state;
  logic [IW-1:0]   clrPtr, wordIdx, wrIdx;
  logic [3:0]      wrEn;
  logic [31:0]     wrData, loadResult;
  logic            accept, err, doLoad, doStore;
  always_comb begin
    wordIdx = Address[ADDR_WIDTH-1:2];
    accept = !reset && state == ST_IDLE && (MemRead | MemWrite);
    err = misaligned(Size, Address[1:0]);
    doStore = accept && MemWrite && !err;
    doLoad = accept && MemRead && !MemWrite && !err;
    wrIdx = state == ST_CLEAR ? clrPtr : wordIdx;
    wrData = state == ST_CLEAR ? (clrPtr == IW'(INIT_ADDR) ? INIT_VALUE : 32'd0) :
             Size == SIZE_BYTE ? {4{WriteData[7:0]}} :
             Size == SIZE_HALF ? {2{WriteData[15:0]}} : WriteData;
    wrEn = reset ? 4'h0 : state == ST_CLEAR ? 4'hF : !doStore ? 4'h0 :
           Size == SIZE_BYTE ? 4'b0001 << Address[1:0] :
           Size == SIZE_HALF ? (Address[1] ? 4'b1100 : 4'b0011) : 4'hF;
  end
  mem_load_align uAlign (
    .word    (mem[wordIdx]),
    .lane    (Address[1:0]),
    .size    (Size),
    .zeroExt (Unsigned),
    .result  (loadResult)
  );
  // Per-lane enables let subword stores update in one cycle without reading the word first.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (wrEn[i]) mem[wrIdx][i] <= wrData[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      clrPtr <= '0;
      ReadData <= '0;
      ReadValid <= 1'b0;
      Ready <= 1'b0;
      AddrError <= 1'b0;
    end else begin
      ReadValid <= doLoad;
      AddrError <= accept && err;
      if (doLoad) ReadData <= loadResult;
      if (state == ST_CLEAR) begin
        clrPtr <= clrPtr + 1'b1;
        if (clrPtr == IW'(DEPTH_WORDS - 1)) begin
          state <= ST_IDLE;
          Ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and randomized checks of data_mem_ctrl against a byte-array model.
module tb_data_mem_ctrl;
  logic        clk, reset;
  logic [8:0]  Address;
  logic [31:0] WriteData, ReadData;
  logic        MemWrite, MemRead, Unsigned, ReadValid, Ready, AddrError;
  logic [1:0]  Size;
  int          vec = 0;
  int          errs = 0;
  logic [7:0]  refMem [512];
  logic [31:0] lastData;
  logic        expValid, expErr;

  data_mem_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Size      (Size),
    .Unsigned  (Unsigned),
    .ReadData  (ReadData),
    .ReadValid (ReadValid),
    .Ready     (Ready),
    .AddrError (AddrError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic merr(input logic [8:0] a, input logic [1:0] sz);
    return sz == 2'd3 || (int'(a) % (1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] mload(input logic [8:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v = 32'd0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[int'(a) + i];
    if (n == 1) return u ? v : {{24{v[7]}}, v[7:0]};
    if (n == 2) return u ? v : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic mstore(input logic [8:0] a, input logic [31:0] d, input logic [1:0] sz);
    for (int i = 0; i < (1 << sz); i++) refMem[int'(a) + i] = d[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 512; i++) refMem[i] = 8'd0;
    refMem[52] = 8'd3;
    lastData = 32'd0;
  endtask

  // One request per cycle; returns at the next negedge with that request's results visible.
  task automatic drive(input logic wr, input logic rd, input logic [8:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u);
    expErr = (wr | rd) && merr(a, sz);
    expValid = rd && !wr && !expErr;
    if (expValid) lastData = mload(a, sz, u);
    MemWrite = wr; MemRead = rd; Address = a; WriteData = d; Size = sz; Unsigned = u;
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    if (wr && !expErr) mstore(a, d, sz);
  endtask

  task automatic test_reset(input int pulseAt);
    int k = 0;
    int p = pulseAt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    vec++;
    if (Ready !== 1'b0 || ReadValid !== 1'b0 || AddrError !== 1'b0 || ReadData !== 32'd0) begin
      errs++;
      $display("FAIL reset_state: Ready=%b ReadValid=%b AddrError=%b ReadData=%h, want 0 0 0 00000000",
               Ready, ReadValid, AddrError, ReadData);
    end
    while (k < 129) begin
      k++;
      MemWrite = (k == 5); MemRead = (k == 6);
      Address = (k == 5) ? 9'h44 : 9'h11;
      WriteData = 32'hA5A5A5A5; Size = 2'd2; Unsigned = 1'b0;
      @(negedge clk);
      MemWrite = 1'b0; MemRead = 1'b0;
      vec++;
      if (Ready !== (k >= 128) || ReadValid !== 1'b0 || AddrError !== 1'b0) begin
        errs++;
        $display("FAIL clear_cycle_%0d: Ready=%b ReadValid=%b AddrError=%b, want %b 0 0",
                 k, Ready, ReadValid, AddrError, k >= 128);
      end
      if (k == p) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        p = 0;
      end
    end
  endtask

  task automatic test_init_reads();
    logic [8:0]  ad [4] = '{9'h34, 9'h00, 9'h44, 9'h34};
    logic [31:0] ex [4] = '{32'h3, 32'h0, 32'h0, 32'h3};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, ad[i], 32'd0, 2'd2, 1'b0);
      vec++;
      if (ReadValid !== 1'b1 || ReadData !== ex[i]) begin
        errs++;
        $display("FAIL init_lw_%h: ReadValid=%b ReadData=%h, want 1 %h", ad[i], ReadValid, ReadData, ex[i]);
      end
    end
    drive(1'b0, 1'b0, 9'h0, 32'd0, 2'd2, 1'b0);
    vec++;
    if (ReadValid !== 1'b0 || ReadData !== 32'h3) begin
      errs++;
      $display("FAIL read_hold: ReadValid=%b ReadData=%h, want 0 00000003", ReadValid, ReadData);
    end
  endtask

  task automatic test_subword();
    logic [8:0]  ad [4] = '{9'h11, 9'h13, 9'h12, 9'h10};
    logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        us [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ex [4] = '{32'hFFFFFFBE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    drive(1'b1, 1'b0, 9'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    vec++;
    if (ReadValid !== 1'b0 || AddrError !== 1'b0) begin
      errs++;
      $display("FAIL sw_no_valid: ReadValid=%b AddrError=%b, want 0 0", ReadValid, AddrError);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, ad[i], 32'd0, sz[i], us[i]);
      vec++;
      if (ReadValid !== 1'b1 || ReadData !== ex[i]) begin
        errs++;
        $display("FAIL subword_load_%0d: ReadValid=%b ReadData=%h, want 1 %h", i, ReadValid, ReadData, ex[i]);
      end
    end
  endtask

  task automatic test_store_merge();
    drive(1'b1, 1'b0, 9'h12, 32'h0000005A, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 9'h10, 32'd0, 2'd2, 1'b0);
    vec++;
    if (ReadData !== 32'hDE5ABEEF) begin
      errs++;
      $display("FAIL sb_merge: ReadData=%h, want de5abeef", ReadData);
    end
    drive(1'b1, 1'b0, 9'h10, 32'hFFFF1234, 2'd1, 1'b0);
    drive(1'b0, 1'b1, 9'h10, 32'd0, 2'd2, 1'b0);
    vec++;
    if (ReadData !== 32'hDE5A1234) begin
      errs++;
      $display("FAIL sh_merge: ReadData=%h, want de5a1234", ReadData);
    end
  endtask

  task automatic test_errors();
    logic        wr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0]  ad [4] = '{9'h11, 9'h13, 9'h10, 9'h10};
    logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      drive(wr[i], !wr[i], ad[i], 32'hFFFFFFFF, sz[i], 1'b0);
      vec++;
      if (AddrError !== 1'b1 || ReadValid !== 1'b0 || ReadData !== 32'hDE5A1234) begin
        errs++;
        $display("FAIL addr_error_%0d: AddrError=%b ReadValid=%b ReadData=%h, want 1 0 de5a1234",
                 i, AddrError, ReadValid, ReadData);
      end
      drive(1'b0, 1'b0, 9'h0, 32'd0, 2'd0, 1'b0);
      vec++;
      if (AddrError !== 1'b0) begin
        errs++;
        $display("FAIL addr_error_pulse_%0d: AddrError=%b, want 0", i, AddrError);
      end
    end
    drive(1'b0, 1'b1, 9'h10, 32'd0, 2'd2, 1'b0);
    vec++;
    if (ReadValid !== 1'b1 || ReadData !== 32'hDE5A1234) begin
      errs++;
      $display("FAIL err_no_write: ReadValid=%b ReadData=%h, want 1 de5a1234", ReadValid, ReadData);
    end
  endtask

  task automatic test_read_write_both();
    drive(1'b1, 1'b1, 9'h40, 32'hCAFEF00D, 2'd2, 1'b0);
    vec++;
    if (ReadValid !== 1'b0 || AddrError !== 1'b0 || ReadData !== 32'hDE5A1234) begin
      errs++;
      $display("FAIL rw_both: ReadValid=%b AddrError=%b ReadData=%h, want 0 0 de5a1234",
               ReadValid, AddrError, ReadData);
    end
    drive(1'b0, 1'b1, 9'h40, 32'd0, 2'd2, 1'b0);
    vec++;
    if (ReadValid !== 1'b1 || ReadData !== 32'hCAFEF00D) begin
      errs++;
      $display("FAIL rw_both_readback: ReadValid=%b ReadData=%h, want 1 cafef00d", ReadValid, ReadData);
    end
  endtask

  task automatic test_random();
    int         r;
    logic       wr, rd;
    logic [8:0] a;
    logic [1:0] sz;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      wr = r < 30 || r >= 95;
      rd = (r >= 30 && r < 90) || r >= 95;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd2) a[1:0] = 2'b00;
        else if (sz == 2'd1) a[0] = 1'b0;
      end
      drive(wr, rd, a, $urandom, sz, 1'($urandom_range(0, 1)));
      vec++;
      if (ReadValid !== expValid || AddrError !== expErr || ReadData !== lastData) begin
        errs++;
        $display("FAIL random_%0d: wr=%b rd=%b a=%h sz=%0d got RV=%b AE=%b RD=%h, want %b %b %h",
                 n, wr, rd, a, sz, ReadValid, AddrError, ReadData, expValid, expErr, lastData);
      end
    end
  endtask

  task automatic test_reset_again();
    drive(1'b1, 1'b0, 9'h20, 32'h12345678, 2'd2, 1'b0);
    test_reset(0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, i == 0 ? 9'h20 : 9'h34, 32'd0, 2'd2, 1'b0);
      vec++;
      if (ReadValid !== 1'b1 || ReadData !== (i == 0 ? 32'h0 : 32'h3)) begin
        errs++;
        $display("FAIL post_reset_lw_%0d: ReadValid=%b ReadData=%h, want 1 %h",
                 i, ReadValid, ReadData, i == 0 ? 32'h0 : 32'h3);
      end
    end
    test_reset(40);
    drive(1'b0, 1'b1, 9'h44, 32'd0, 2'd2, 1'b0);
    vec++;
    if (ReadValid !== 1'b1 || ReadData !== 32'h0) begin
      errs++;
      $display("FAIL clear_store_ignored: ReadValid=%b ReadData=%h, want 1 00000000", ReadValid, ReadData);
    end
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Address = 9'h0;
    WriteData = 32'd0; Size = 2'd0; Unsigned = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset(0);
    test_init_reads();
    test_subword();
    test_store_merge();
    test_errors();
    test_read_write_both();
    test_random();
    test_reset_again();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised byte-addressable MIPS data memory with subword load/store (lb/lbu/lh/lhu/lw, sb/sh/sw) and a registered read path.
- After every reset, a built-in clear sequencer zeroes the whole array and then preloads one initial constant.
- Misaligned accesses are flagged.
- Sits between the MEM-stage address/data path and the write-back mux.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words; power of two, >= 16.
ADDR_WIDTH, 9, byte-address width; must equal clog2(DEPTH_WORDS)+2.
INIT_ADDR, 13, word index preloaded after clear.
INIT_VALUE, 32'd3, value written to INIT_ADDR during clear.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
Address  in  ADDR_WIDTH  byte address; Address[1:0] selects the byte lane (little-endian).
WriteData  in  32  store data; byte uses [7:0], half uses [15:0].
MemWrite  in  1  store request.
MemRead  in  1  load request.
Size  in  2  00 byte, 01 half, 10 word, 11 reserved.
Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
ReadData  out  32  registered load result.
ReadValid  out  1  one-cycle pulse; ReadData updated this cycle.
Ready  out  1  accepting requests.
AddrError  out  1  one-cycle pulse, misaligned or reserved access.

Behaviour:
Clock and reset:
- Single clock `clk`; `reset` is synchronous and active-high.
- On a clk edge with reset=1: state<=CLEAR, ClrPtr<=0, ReadData<=0, ReadValid<=0, Ready<=0, AddrError<=0.
- Reset asserted during CLEAR restarts the clear at word 0.

CLEAR state:
- Each cycle writes 0 to word ClrPtr, or INIT_VALUE when ClrPtr==INIT_ADDR, then ClrPtr++.
- Edges 1..DEPTH_WORDS after reset deassertion clear words 0..DEPTH_WORDS-1.
- After writing the last word: state<=IDLE and Ready<=1. Ready is therefore first high DEPTH_WORDS cycles after reset falls.
- MemRead/MemWrite in CLEAR are ignored: no write, no ReadValid, no AddrError.

IDLE state:
- A request is accepted on an edge where Ready=1 and (MemRead|MemWrite)=1.
- MemRead and MemWrite both high: performed as a write only; the read is dropped and ReadValid stays 0.
- Alignment: half requires Address[0]=0; word requires Address[1:0]=0; Size=11 is always an error.
- On error: memory unchanged, ReadValid=0, AddrError=1 on the following cycle for exactly one cycle.

Store:
- Byte: lane Address[1:0] <= WriteData[7:0].
- Half: lanes {Address[1],1:0} <= WriteData[15:0]; the upper half when Address[1]=1.
- Word: all four lanes.
- Unselected lanes are preserved, using per-lane write enables with no read-modify-write cycle.

Load:
- Latency 1: word read registered at the accept edge; ReadData and ReadValid=1 are valid in the next cycle.
- Lane extraction as for stores; extension per Unsigned.
- ReadData holds its last value while no load completes; ReadValid is 0 otherwise.

Ordering:
- A store accepted at edge N is visible to a load accepted at edge N+1.
- Back-to-back loads are allowed every cycle (throughput 1).

Ready:
- Ready is constant 1 in IDLE; there is no backpressure after init.

Decomposition:
- Shared package data_mem_pkg:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD.
  - State encoding ST_CLEAR/ST_IDLE.
  - Function computing the misalignment flag.
- One sub-module, mem_load_align (combinational): inputs are the 32-bit word, Address[1:0], Size and Unsigned; output is the extended 32-bit result. It is instantiated on the registered read path.
- Lane write enables and the clear FSM stay in data_mem_ctrl.

Test Plan:
1. Reset then idle → Ready=0 for 128 cycles and 1 from cycle 128. lw 0x34 (word 13) → ReadData=0x00000003 with ReadValid one cycle later. lw 0x00 → 0x00000000.
2. sw 0xDEADBEEF @0x10, then:
   - lb 0x11 → 0xFFFFFFBE
   - lbu 0x13 → 0x000000DE
   - lh 0x12 → 0xFFFFDEAD
   - lhu 0x10 → 0x0000BEEF
3. After scenario 2: sb 0x5A @0x12, then lw 0x10 → 0xDE5ABEEF. sh 0x1234 @0x10, then lw 0x10 → 0xDE5A1234.
4. lw 0x11 and sh @0x13 → AddrError single-cycle pulse, ReadValid=0; a subsequent lw 0x10 shows the word unchanged. Size=11 @0x10 → AddrError.
5. sw 0x12345678 @0x20, then reset for 1 cycle → Ready=0 for 128 cycles; lw 0x20 → 0x00000000 and lw 0x34 → 3. Pulse reset again at cycle 40 of the clear → Ready rises 128 cycles after the second reset.
6. MemRead=MemWrite=1 with sw 0xCAFEF00D @0x40 → ReadValid stays 0, and a later lw 0x40 returns 0xCAFEF00D. A store issued during CLEAR to 0x44 → a later read returns 0.
